sd_sector_server: RTL and testbench

- Responder side of the core's sector-buffer disk interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*); the floppy controller in pcw_core is the initiator.
- Serves 512-byte sector reads and writes for two drive images held in a byte-wide external memory (SDRAM arbiter port).
- Replaces the host SPI path for images preloaded into RAM; standalone sims and RAM-disk builds use it.

---
 rtl/sd_server_pkg.sv | 12 +
 rtl/sd_sector_server.sv | 180 ++++++++++++++++++
 tb/tb_sd_sector_server.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_server_pkg.sv
// sd_server_pkg: shared state encoding and sector geometry for the sector server.
package sd_server_pkg;

    typedef enum logic [3:0] {
        IDLE, RD_REQ, RD_WAIT, RD_STB, WR_ADDR, WR_LAT, WR_WAIT, DONE, HOLD
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int IDX_W = $clog2(SECTOR_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = 9'd511;

endpackage

// File: rtl/sd_sector_server.sv
// sd_sector_server: answers the core's sector-buffer requests from drive images
// held in byte-wide external memory, one byte transaction at a time.
module sd_sector_server
    import sd_server_pkg::*;
#(
    parameter int            DRIVES = 2,
    parameter int            AW     = 25,
    parameter logic [AW-1:0] BASE0  = 25'h0100000,
    parameter logic [AW-1:0] BASE1  = 25'h0180000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic [DRIVES-1:0] sd_rd,
    input  logic [DRIVES-1:0] sd_wr,
    output logic [DRIVES-1:0] sd_ack,
    output logic [IDX_W-1:0]  sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_dout_strobe,
    input  logic [15:0]       img_sectors0,
    input  logic [15:0]       img_sectors1,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              oor_err
);

    state_t            state_q, state_d;
    logic              drv_q, drv_d;
    logic [31:0]       lba_q, lba_d;
    logic              inr_q, inr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DRIVES-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]  baddr_q, baddr_d;
    logic [7:0]        bdout_q, bdout_d;
    logic              stb_q, stb_d;
    logic              mrd_q, mrd_d;
    logic              mwr_q, mwr_d;
    logic [AW-1:0]     maddr_q, maddr_d;
    logic [7:0]        mwdata_q, mwdata_d;
    logic              oor_q, oor_d;

    logic [DRIVES-1:0] req;
    logic              sel;
    logic              sel_inr;
    logic              last;
    logic [IDX_W-1:0]  idx_inc;
    logic [IDX_W-1:0]  idx_next;
    state_t            wr_next;
    logic [AW-1:0]     mem_addr_calc;

    // Drive 0 wins whenever it has any request pending.
    assign req           = sd_rd | sd_wr;
    assign sel           = !req[0];
    assign sel_inr       = sd_lba < {16'h0, sel ? img_sectors1 : img_sectors0};
    assign last          = idx_q == LAST_IDX;
    assign idx_inc       = idx_q + 1'b1;
    assign idx_next      = last ? idx_q : idx_inc;
    assign wr_next       = last ? DONE : WR_ADDR;
    assign mem_addr_calc = (drv_q ? BASE1 : BASE0) + AW'({lba_q, idx_q});

    always_comb begin
        state_d  = state_q;
        drv_d    = drv_q;
        lba_d    = lba_q;
        inr_d    = inr_q;
        idx_d    = idx_q;
        ack_d    = ack_q;
        baddr_d  = baddr_q;
        bdout_d  = bdout_q;
        stb_d    = 1'b0;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        oor_d    = oor_q;
        case (state_q)
            IDLE: if (|req) begin
                drv_d   = sel;
                lba_d   = sd_lba;
                inr_d   = sel_inr;
                ack_d   = DRIVES'(1) << sel;
                idx_d   = '0;
                baddr_d = '0;
                oor_d   = oor_q | !sel_inr;
                state_d = sd_rd[sel] ? RD_REQ : WR_ADDR;
            end
            // Out-of-range reads still stream a full sector of zeros.
            RD_REQ: begin
                mrd_d   = inr_q;
                maddr_d = inr_q ? mem_addr_calc : maddr_q;
                bdout_d = inr_q ? bdout_q : 8'h00;
                stb_d   = !inr_q;
                baddr_d = inr_q ? baddr_q : idx_q;
                state_d = inr_q ? RD_WAIT : RD_STB;
            end
            RD_WAIT: if (mem_ready) begin
                mrd_d   = 1'b0;
                bdout_d = mem_rdata;
                stb_d   = 1'b1;
                baddr_d = idx_q;
                state_d = RD_STB;
            end
            RD_STB: begin
                idx_d   = idx_next;
                state_d = last ? DONE : RD_REQ;
            end
            WR_ADDR: state_d = WR_LAT;
            WR_LAT: begin
                mwdata_d = sd_buff_din;
                mwr_d    = inr_q;
                maddr_d  = inr_q ? mem_addr_calc : maddr_q;
                idx_d    = inr_q ? idx_q : idx_next;
                baddr_d  = inr_q ? baddr_q : idx_next;
                state_d  = inr_q ? WR_WAIT : wr_next;
            end
            WR_WAIT: if (mem_ready) begin
                mwr_d   = 1'b0;
                idx_d   = idx_next;
                baddr_d = idx_next;
                state_d = wr_next;
            end
            DONE: begin
                ack_d   = '0;
                state_d = HOLD;
            end
            HOLD: state_d = (sd_rd[drv_q] | sd_wr[drv_q]) ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            drv_q    <= 1'b0;
            lba_q    <= '0;
            inr_q    <= 1'b0;
            idx_q    <= '0;
            ack_q    <= '0;
            baddr_q  <= '0;
            bdout_q  <= '0;
            stb_q    <= 1'b0;
            mrd_q    <= 1'b0;
            mwr_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            oor_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            drv_q    <= drv_d;
            lba_q    <= lba_d;
            inr_q    <= inr_d;
            idx_q    <= idx_d;
            ack_q    <= ack_d;
            baddr_q  <= baddr_d;
            bdout_q  <= bdout_d;
            stb_q    <= stb_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            oor_q    <= oor_d;
        end
    end

    assign sd_ack         = ack_q;
    assign sd_buff_addr   = baddr_q;
    assign sd_buff_dout   = bdout_q;
    assign sd_dout_strobe = stb_q;
    assign mem_rd         = mrd_q;
    assign mem_wr         = mwr_q;
    assign mem_addr       = maddr_q;
    assign mem_wdata      = mwdata_q;
    assign oor_err        = oor_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// tb_sd_sector_server: directed sector transfers against a memory model with
// 2-cycle latency and a registered core buffer holding 8'hA5 ^ addr.
module tb_sd_sector_server;

    localparam logic [24:0] B0 = 25'h0100000;
    localparam logic [24:0] B1 = 25'h0180000;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic [1:0]  sd_rd = '0;
    logic [1:0]  sd_wr = '0;
    logic [1:0]  sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din = '0;
    logic        sd_dout_strobe;
    logic [15:0] img_sectors0 = '0;
    logic [15:0] img_sectors1 = '0;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        oor_err;

    int checks = 0;
    int failures = 0;

    sd_sector_server dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_dout_strobe(sd_dout_strobe),
        .img_sectors0(img_sectors0), .img_sectors1(img_sectors1),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .oor_err(oor_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Core buffer RAM: synchronous read, data one cycle after the address.
    always @(posedge clk_sys) sd_buff_din <= 8'hA5 ^ sd_buff_addr[7:0];

    int lat_cnt;
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt   <= 0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            if ((mem_rd || mem_wr) && !mem_ready) begin
                if (lat_cnt == 1) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem_addr[7:0];
                    lat_cnt   <= 0;
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    logic [16:0] stb_log[$];
    logic [32:0] wr_log[$];
    logic [24:0] rda_log[$];
    int rd_cycles = 0;
    int overlap = 0;
    always @(negedge clk_sys) begin
        if (sd_dout_strobe) stb_log.push_back({sd_buff_addr, sd_buff_dout});
        if (mem_rd) rd_cycles++;
        if (mem_rd && mem_wr) overlap++;
        if (mem_ready && mem_wr) wr_log.push_back({mem_addr, mem_wdata});
        if (mem_ready && mem_rd) rda_log.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_ack(input logic [1:0] want, input int budget, input string tag);
        int i;
        i = 0;
        while (sd_ack !== want && i < budget) begin
            tick(1);
            i++;
        end
        chk(tag, sd_ack, want);
    endtask

    task automatic check_read(input string tag, input int sb, input int rb, input int rc,
                              input logic [24:0] a0, input bit oor);
        int nbad;
        logic [24:0] a;
        logic [8:0]  kk;
        nbad = 0;
        chk({tag, "_strobes"}, stb_log.size() - sb, 512);
        for (int k = 0; k < 512; k++) begin
            a  = a0 + 25'(k);
            kk = 9'(k);
            if (sb + k >= stb_log.size()) nbad++;
            else if (stb_log[sb + k] !== {kk, oor ? 8'h00 : a[7:0]}) nbad++;
            if (!oor) begin
                if (rb + k >= rda_log.size()) nbad++;
                else if (rda_log[rb + k] !== a) nbad++;
            end
        end
        chk({tag, "_bad_bytes"}, nbad, 0);
        chk({tag, "_mem_reads"}, rda_log.size() - rb, oor ? 0 : 512);
        if (oor) chk({tag, "_rd_cycles"}, rd_cycles - rc, 0);
    endtask

    task automatic check_write(input string tag, input int wb, input logic [24:0] a0);
        int nbad;
        logic [7:0] kd;
        nbad = 0;
        chk({tag, "_writes"}, wr_log.size() - wb, 512);
        for (int k = 0; k < 512; k++) begin
            kd = 8'(k);
            if (wb + k >= wr_log.size()) nbad++;
            else if (wr_log[wb + k] !== {a0 + 25'(k), 8'hA5 ^ kd}) nbad++;
        end
        chk({tag, "_bad_bytes"}, nbad, 0);
    endtask

    function automatic logic [55:0] outs();
        return {sd_ack, sd_buff_addr, sd_buff_dout, sd_dout_strobe, mem_rd, mem_wr,
                mem_addr, mem_wdata, oor_err};
    endfunction

    initial begin
        int sb, rb, rc, wb, i;
        img_sectors0 = 16'd10;
        img_sectors1 = 16'd4;
        tick(3);
        chk("reset_outputs", outs(), 0);
        reset_n = 1'b1;
        tick(1);

        // Drive 0 read, lba 3
        sb = stb_log.size(); rb = rda_log.size(); rc = rd_cycles;
        sd_lba = 32'd3;
        sd_rd = 2'b01;
        tick(1);
        chk("rd0_ack_latency", sd_ack, 2'b01);
        wait_ack(2'b00, 6000, "rd0_done");
        chk("rd0_oor", oor_err, 1'b0);
        sd_rd = 2'b00;
        tick(2);
        check_read("rd0", sb, rb, rc, B0 + 25'd1536, 1'b0);

        // Drive 1 write, lba 0
        wb = wr_log.size();
        sd_lba = 32'd0;
        sd_wr = 2'b10;
        tick(1);
        chk("wr1_ack_latency", sd_ack, 2'b10);
        wait_ack(2'b00, 8000, "wr1_done");
        sd_wr = 2'b00;
        tick(2);
        check_write("wr1", wb, B1);

        // Out-of-range read on drive 0
        sb = stb_log.size(); rb = rda_log.size(); rc = rd_cycles;
        sd_lba = 32'd10;
        sd_rd = 2'b01;
        tick(1);
        chk("oor_ack", sd_ack, 2'b01);
        chk("oor_set", oor_err, 1'b1);
        wait_ack(2'b00, 6000, "oor_done");
        sd_rd = 2'b00;
        tick(2);
        check_read("oor", sb, rb, rc, 25'd0, 1'b1);
        chk("oor_sticky", oor_err, 1'b1);

        // Drive 1 read and drive 0 write together: drive 0 first, then HOLD
        wb = wr_log.size(); sb = stb_log.size(); rb = rda_log.size(); rc = rd_cycles;
        sd_lba = 32'd1;
        sd_wr = 2'b01;
        sd_rd = 2'b10;
        tick(1);
        chk("prio_ack", sd_ack, 2'b01);
        wait_ack(2'b00, 8000, "prio_wr_done");
        tick(10);
        chk("hold_blocks_d1", sd_ack, 2'b00);
        chk("hold_no_strobes", stb_log.size() - sb, 0);
        sd_wr = 2'b00;
        wait_ack(2'b10, 4, "d1_after_hold");
        wait_ack(2'b00, 6000, "d1_rd_done");
        sd_rd = 2'b00;
        tick(2);
        check_write("prio_wr0", wb, B0 + 25'd512);
        check_read("rd1", sb, rb, rc, B1 + 25'd512, 1'b0);
        chk("oor_still_set", oor_err, 1'b1);

        // Request held high after completion
        sb = stb_log.size();
        sd_lba = 32'd2;
        sd_rd = 2'b01;
        tick(1);
        chk("held_ack", sd_ack, 2'b01);
        wait_ack(2'b00, 6000, "held_done");
        tick(30);
        chk("held_no_reack", sd_ack, 2'b00);
        chk("held_one_sector", stb_log.size() - sb, 512);
        sd_rd = 2'b00;
        tick(1);
        sd_rd = 2'b01;
        wait_ack(2'b01, 4, "rerequest_ack");

        // Asynchronous reset at byte 100 of that read
        i = 0;
        while (!(sd_dout_strobe && sd_buff_addr == 9'd100) && i < 2000) begin
            tick(1);
            i++;
        end
        chk("reached_byte100", sd_dout_strobe && sd_buff_addr == 9'd100, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", outs(), 0);
        sd_rd = 2'b00;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        sb = stb_log.size(); rb = rda_log.size(); rc = rd_cycles;
        sd_lba = 32'd5;
        sd_rd = 2'b01;
        tick(1);
        chk("post_reset_ack", sd_ack, 2'b01);
        wait_ack(2'b00, 6000, "post_reset_done");
        sd_rd = 2'b00;
        tick(2);
        check_read("post_reset", sb, rb, rc, B0 + 25'd2560, 1'b0);
        chk("post_reset_oor", oor_err, 1'b0);
        chk("rd_wr_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
